// File: rtl/dct_transpose_buf_pkg.sv
// Shared definitions for the DCT transpose stage: block geometry, default
// coefficient width and the read-side state encoding.
package dct_transpose_buf_pkg;

    localparam int BLK_DIM     = 8;
    localparam int SIZE_IN_DEF = 10;
    localparam int ROW_W       = 3;

    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_e;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(BLK_DIM - 1);

endpackage

// File: rtl/dct_transpose_buf_if.sv
// Block-in / row-out bundle between the column DCT, the transpose buffer and
// the row DCT. The slave modport is the buffer's view.
interface dct_transpose_buf_if
    import dct_transpose_buf_pkg::*;
#(
    parameter int SIZE_IN = SIZE_IN_DEF
);

    logic [7:0][7:0][SIZE_IN-1:0] blk_in;
    logic                         blk_valid;
    logic                         blk_ready;
    logic [7:0][SIZE_IN-1:0]      row_out;
    logic                         row_valid;
    logic                         row_ready;
    logic [ROW_W-1:0]             row_idx;
    logic                         row_last;
    logic                         blk_start;
    logic                         overflow;

    modport master (
        output blk_in, blk_valid, row_ready,
        input  blk_ready, row_out, row_valid, row_idx, row_last, blk_start, overflow
    );

    modport slave (
        input  blk_in, blk_valid, row_ready,
        output blk_ready, row_out, row_valid, row_idx, row_last, blk_start, overflow
    );

endinterface

// File: rtl/dct_blk_buf.sv
// One 8x8 coefficient bank: whole-block load in a single edge, transposed
// row read (row_o[c] = stored[c][row_sel_i]). Contents are intentionally unreset.
module dct_blk_buf
    import dct_transpose_buf_pkg::*;
#(
    parameter int SIZE_IN = SIZE_IN_DEF
) (
    input  logic                         clk,
    input  logic                         load_i,
    input  logic [7:0][7:0][SIZE_IN-1:0] blk_i,
    input  logic [ROW_W-1:0]             row_sel_i,
    output logic [7:0][SIZE_IN-1:0]      row_o
);

    logic [7:0][7:0][SIZE_IN-1:0] mem_q;

    always_ff @(posedge clk) begin
        if (load_i) begin
            mem_q <= blk_i;
        end
    end

    always_comb begin
        row_o = '0;
        for (int c = 0; c < BLK_DIM; c++) begin
            row_o[c] = mem_q[c][row_sel_i];
        end
    end

endmodule

// File: rtl/dct_transpose_buf.sv
// Ping-pong transpose buffer between the column and row DCT stages: captures a
// whole column-DCT block per strobe and streams it back out one row at a time.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// RD_IDLE   | no block being streamed; waits for full[rd_sel]
// RD_STREAM | presenting row row_idx of bank rd_sel until row_ready
module dct_transpose_buf
    import dct_transpose_buf_pkg::*;
#(
    parameter int SIZE_IN = SIZE_IN_DEF,
    parameter int DIM     = BLK_DIM
) (
    input  logic                clk,
    input  logic                rst_n,
    dct_transpose_buf_if.slave  bus
);

    if (DIM != BLK_DIM) begin : g_bad_dim
        $error("dct_transpose_buf: only an 8x8 block is supported");
    end

    logic [1:0]                   full_q, full_d;
    logic                         wr_sel_q, wr_sel_d;
    logic                         rd_sel_q, rd_sel_d;
    logic                         overflow_q, overflow_d;

    rd_state_e                    state_q;
    logic [ROW_W-1:0]             row_idx_q;
    logic                         row_valid_q;
    logic                         row_last_q;
    logic                         blk_start_q;

    logic                         blk_ready;
    logic                         capture;
    logic                         drop;
    logic                         release_blk;
    logic [1:0][7:0][SIZE_IN-1:0] bank_row;

    assign blk_ready   = ~(full_q[0] & full_q[1]);
    assign capture     = bus.blk_valid & blk_ready;
    assign drop        = bus.blk_valid & ~blk_ready;
    assign release_blk = (state_q == RD_STREAM) && bus.row_ready && (row_idx_q == LAST_ROW);

    // Fill and drain alternate strictly, so wr_sel never lands on a full bank
    // while blk_ready is high; release and capture always touch different banks.
    always_comb begin
        full_d     = full_q;
        wr_sel_d   = wr_sel_q;
        rd_sel_d   = rd_sel_q;
        overflow_d = overflow_q | drop;
        if (release_blk) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = ~rd_sel_q;
        end
        if (capture) begin
            full_d[wr_sel_q] = 1'b1;
            wr_sel_d         = ~wr_sel_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q     <= 2'b00;
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            full_q     <= full_d;
            wr_sel_q   <= wr_sel_d;
            rd_sel_q   <= rd_sel_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RD_IDLE;
            row_idx_q   <= '0;
            row_valid_q <= 1'b0;
            row_last_q  <= 1'b0;
            blk_start_q <= 1'b0;
        end else begin
            blk_start_q <= 1'b0;
            case (state_q)
                RD_IDLE: begin
                    if (full_q[rd_sel_q]) begin
                        state_q     <= RD_STREAM;
                        row_idx_q   <= '0;
                        row_valid_q <= 1'b1;
                        row_last_q  <= 1'b0;
                        blk_start_q <= 1'b1;
                    end
                end
                RD_STREAM: begin
                    if (bus.row_ready) begin
                        if (row_idx_q != LAST_ROW) begin
                            row_idx_q  <= row_idx_q + 3'd1;
                            row_last_q <= (row_idx_q == LAST_ROW - 3'd1);
                        end else if (full_q[!rd_sel_q]) begin
                            // next block already waiting: restart at row 0 with no bubble
                            row_idx_q   <= '0;
                            row_last_q  <= 1'b0;
                            blk_start_q <= 1'b1;
                        end else begin
                            state_q     <= RD_IDLE;
                            row_idx_q   <= '0;
                            row_valid_q <= 1'b0;
                            row_last_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q     <= RD_IDLE;
                    row_valid_q <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        dct_blk_buf #(
            .SIZE_IN (SIZE_IN)
        ) u_buf (
            .clk       (clk),
            .load_i    (capture && (wr_sel_q == 1'(g))),
            .blk_i     (bus.blk_in),
            .row_sel_i (row_idx_q),
            .row_o     (bank_row[g])
        );
    end

    assign bus.blk_ready = blk_ready;
    assign bus.row_out   = bank_row[rd_sel_q];
    assign bus.row_valid = row_valid_q;
    assign bus.row_idx   = row_idx_q;
    assign bus.row_last  = row_last_q;
    assign bus.blk_start = blk_start_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: doc/dct_transpose_buf.md
DCT_TRANSPOSE_BUF -- requirements
Module: dct_transpose_buf

Interface
REQ-001 Parameter SIZE_IN, default 10, signed width of each coefficient from the column DCT stage (SIZE+2).
REQ-002 Parameter DIM, default 8, block dimension; only 8 is supported.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 blk_in  in  [7:0][7:0] x SIZE_IN signed  column-DCT block; blk_in[c][k] = coefficient k of column c.
REQ-006 blk_valid  in  1  one-cycle strobe; blk_in is complete (driven from the stage-1 done).
REQ-007 blk_ready  out  1  at least one of the two buffers is free.
REQ-008 row_out  out  [7:0] x SIZE_IN signed  transposed row r: row_out[c] = blk_in[c][r] of the streaming block.
REQ-009 row_valid  out  1  row_out, row_idx and row_last are valid.
REQ-010 row_ready  in  1  downstream row-DCT stage accepts the row this cycle.
REQ-011 row_idx  out  3  index r of the current row.
REQ-012 row_last  out  1  high with row_valid when row_idx = 7.
REQ-013 blk_start  out  1  one-cycle pulse on the cycle row 0 of a block first becomes valid.
REQ-014 overflow  out  1  sticky; a block arrived with no free buffer.

Function
REQ-015 Two SIZE_IN x 64 buffers (ping/pong), each with a full flag; wr_sel points to the next buffer to fill; rd_sel points to the buffer being streamed.
REQ-016 blk_ready = NOT(full[0] AND full[1]), combinational from registered flags.
REQ-017 blk_valid AND blk_ready: all 64 coefficients are latched into buffer wr_sel in one edge; full[wr_sel] set; wr_sel toggles.
REQ-018 blk_valid AND NOT blk_ready: block dropped; no buffer or pointer changes; overflow set until reset.
REQ-019 Read FSM states: IDLE, STREAM.
REQ-020 IDLE -> STREAM on the edge where full[rd_sel] is 1 at the start of the cycle; row_idx = 0; a block captured at edge N yields row_valid at cycle N+1 (one-cycle latency).
REQ-021 STREAM: row_valid = 1; row_out, row_idx and row_last hold steady until row_valid AND row_ready.
REQ-022 Handshake with row_idx < 7: row_idx increments.
REQ-023 Handshake with row_idx = 7: full[rd_sel] cleared; rd_sel toggles; if the other buffer is full, stay in STREAM with row_idx = 0 (back-to-back, no bubble); else go to IDLE.
REQ-024 blk_start pulses for one cycle on every entry to row 0 of a new block (from IDLE or back-to-back), independent of row_ready.
REQ-025 Capture and final-row release in the same cycle are both performed; a buffer freed at edge N is reported by blk_ready only from cycle N+1.
REQ-026 A capture never writes the buffer at rd_sel while that buffer is full.
REQ-027 row_out is a pure mux of stored data; no arithmetic, no width change; sign preserved.

Reset
REQ-028 rst_n low, asynchronously: full = 00, wr_sel = 0, rd_sel = 0, FSM = IDLE, row_idx = 0, row_valid = 0, row_last = 0, blk_start = 0, overflow = 0.
REQ-029 Buffer data is not reset; row_out is don't-care while row_valid = 0.
REQ-030 Reset asserted mid-stream discards both buffers; the first post-reset block starts at row 0.

Structure
REQ-031 The shared DCT package holds DIM, the default SIZE_IN, and the read FSM state enum.
REQ-032 One sub-module, dct_blk_buf: a single 8x8 storage bank with load strobe and row-select transposed read port, instantiated twice.

Verification
REQ-033 Load blk_in[c][k] = 8c+k, row_ready = 1 -> rows 0..7 in 8 consecutive cycles, row_out[c] = 8c+r; blk_start at row 0; row_last at row 7.
REQ-034 Values -512 and +511 (SIZE_IN = 10) in a block -> output bit-exact with sign preserved.
REQ-035 Two blocks 1 cycle apart, row_ready = 1 -> 16 contiguous valid rows; blk_start at rows 0 and 8; blk_ready low after the second capture.
REQ-036 row_ready toggled 1010... -> each row held until accepted; row_idx never skips; 8 handshakes per block.
REQ-037 Three blocks with row_ready = 0 -> the third is dropped; overflow = 1; the first two still stream in order once row_ready = 1.
REQ-038 rst_n pulsed low at row 4 -> outputs reset immediately (asynchronously); the next block streams from row 0 with blk_start.
